// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: fetches bitstream words from a valid/ready source and
// shifts them LSB-first into a ccff chain of CHAIN_LEN bits, tracking tail parity.
module ccff_chain_loader #(
   parameter int WORD_W    = 8,
   parameter int CHAIN_LEN = 64
) (
   input  logic              prog_clk,
   input  logic              prog_rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              tail_parity
);

   localparam int CW = $clog2(CHAIN_LEN + 1);
   localparam int WW = $clog2(WORD_W + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CHAIN_LEN - 1);
   localparam logic [WW-1:0] WBIT_LAST = WW'(WORD_W - 1);

   typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WW-1:0]     wbit_q, wbit_d;
   logic [WORD_W-1:0] sreg_q, sreg_d;
   logic              parity_q, parity_d;
   logic              shift_en;
   logic              xfer;

   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // abort overrides every other transition; the chain-length limit wins over a word boundary
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   if (word_valid) state_d = SHIFT;
            SHIFT: begin
               if (cnt_q == CNT_LAST)        state_d = DONE;
               else if (wbit_q == WBIT_LAST) state_d = FETCH;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      word_ready    = (state_q == FETCH) && !abort;
      shift_en      = (state_q == SHIFT) && !abort;
      ccff_shift_en = shift_en;
      ccff_head     = shift_en & sreg_q[0];
      busy          = (state_q != IDLE);
      done          = (state_q == DONE);
      tail_parity   = parity_q;
   end

   assign xfer = word_ready && word_valid;

   always_comb begin
      cnt_d    = cnt_q;
      wbit_d   = wbit_q;
      sreg_d   = sreg_q;
      parity_d = parity_q;
      if ((state_q == IDLE) && start && !abort) begin
         cnt_d    = '0;
         parity_d = 1'b0;
      end
      if (xfer) begin
         sreg_d = word_data;
         wbit_d = '0;
      end
      if (shift_en) begin
         sreg_d   = sreg_q >> 1;
         wbit_d   = wbit_q + 1'b1;
         cnt_d    = cnt_q + 1'b1;
         parity_d = parity_q ^ ccff_tail;
      end
   end

   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         cnt_q    <= '0;
         wbit_q   <= '0;
         sreg_q   <= '0;
         parity_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         wbit_q   <= wbit_d;
         sreg_q   <= sreg_d;
         parity_q <= parity_d;
      end
   end

endmodule
